mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port synchronous data/instruction memory between three requesters: CPU instruction fetch (i), CPU load/store (d) and the debug monitor (m). Requests are granted round-robin, and the memory access is sequenced through a fixed-latency FSM. Each access completes with a one-cycle per-port acknowledge, with read data on a shared bus. The block sits between the CPU/monitor and the memory, so the CPU stalls on its own request until it sees its acknowledge.

## Interface
- AW, 10, word-address width
- DW, 32, data width
- LAT, 1, memory read latency in cycles after mem_en (legal range 1..7)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- i_req, d_req, m_req  in  1 each  access request, held until the matching ack
- i_addr, d_addr, m_addr  in  AW each  word address
- d_we, m_we  in  1 each  write enable (fetch port is read-only)
- d_wdata, m_wdata  in  DW each  write data
- i_ack, d_ack, m_ack  out  1 each  one-cycle completion pulse
- rdata  out  DW  read data, valid in the ack cycle of a read
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- owner  out  2  current grant: 0 none, 1 i, 2 d, 3 m
- busy  out  1  high whenever state is not IDLE

## Operation
- **FSM states:** IDLE, ACCESS, WAIT, RESP.
- **IDLE:**
  - If any req is high, pick a winner by round-robin from the port after last_grant. Order is i→d→m→i.
  - Latch the winner's addr/we/wdata, set owner, update last_grant, go to ACCESS.
  - No request: stay in IDLE.
- **ACCESS (1 cycle):** mem_en=1; mem_we = latched we; mem_addr/mem_wdata = latched values. Load wait counter with LAT, go to WAIT.
- **WAIT (LAT cycles):** mem_en=0; counter decrements. In the cycle the counter reaches 1, capture mem_rdata into the rdata register on reads only, then go to RESP.
- **RESP (1 cycle):** assert the owner's ack; rdata is valid for reads. On writes, rdata holds its previous value. Go to IDLE and clear owner.
- **Request inputs:**
  - Sampled only in IDLE.
  - A req dropped mid-access is illegal; the access completes and is acked anyway.
  - Requests seen in the RESP cycle are ignored.
- All outputs are registered; there are no combinational paths from req to outputs.
- **Reset:**
  - State=IDLE, last_grant=m (so i has first priority), owner=0, busy=0.
  - All acks, mem_en and mem_we are 0; mem_addr, mem_wdata and rdata are 0.
- **Reset mid-access:** the access is abandoned with no ack. A write already strobed in ACCESS is not undone. After release, requests still pending are arbitrated afresh.

## Timing
- Request sampled in IDLE at cycle T:
  - mem_en at T+1
  - mem_rdata captured at T+1+LAT
  - ack at T+2+LAT
- Earliest next grant is sampled at T+3+LAT, giving a throughput of one access per LAT+3 cycles.
- The requester must deassert req, or present a new request, in the cycle after ack. A req still high at T+3+LAT is treated as a new request.
- Fairness: a continuously asserted request is granted within 2 other grants.

## Structure
- **Shared package (mem_arb_pkg):**
  - state encoding: IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, RESP=2'd3
  - owner/port IDs: NONE=0, I=1, D=2, M=3
- **Sub-module rr_pick3:** combinational 3-way round-robin picker. Inputs: 3-bit req vector and last_grant; output: winner ID or NONE. Instantiated once.
- The top level contains the FSM, the wait counter (3 bits), and the latch/rdata registers.

## Test plan
- **Single fetch read, LAT=1:** mem word 0x010 = 0xDEADBEEF, i_req at T → mem_en=1 and mem_addr=0x010 at T+1; i_ack=1 and rdata=0xDEADBEEF at T+3; busy low at T+4.
- **Simultaneous requests after reset:** i, d and m all raise req at T → grants in order i, d, m; acks at T+3, T+7, T+11; owner sequence 1, 2, 3.
- **Data write then monitor read:** d_we=1, d_addr=5, d_wdata=0x12345678 → mem_we=1 at T+1, d_ack at T+3, rdata unchanged. Then m reads addr 5 → m_ack with rdata=0x12345678.
- **LAT=3 instance:** d read of addr 7 → mem_en at T+1, d_ack at T+5; next grant is sampled no earlier than T+6.
- **Reset during WAIT:** rst pulsed at T+2 → all outputs 0 immediately; no ack ever issued for that request. After release with i_req still high, a fresh grant is made and i_ack arrives LAT+2 cycles later.
- **Fairness:** m_req held high while i_req is re-asserted every cycle after each ack → m_ack occurs no later than the second grant after m_req rises.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory port arbiter: FSM states and port/owner IDs.
package mem_arb_pkg;

  typedef logic [1:0] state_t;
  typedef logic [1:0] port_id_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCESS = 2'd1;
  localparam state_t WAIT   = 2'd2;
  localparam state_t RESP   = 2'd3;

  localparam port_id_t PORT_NONE = 2'd0;
  localparam port_id_t PORT_I    = 2'd1;
  localparam port_id_t PORT_D    = 2'd2;
  localparam port_id_t PORT_M    = 2'd3;

endpackage

// File: rtl/rr_pick3.sv
// Combinational three-way round-robin picker; search starts at the port after last_grant.
module rr_pick3
  import mem_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last_grant,
  output logic [1:0] winner
);

  // req[0]=i, req[1]=d, req[2]=m; priority rotates i->d->m->i
  always_comb begin
    winner = PORT_NONE;
    case (last_grant)
      PORT_I: begin
        if (req[1])      winner = PORT_D;
        else if (req[2]) winner = PORT_M;
        else if (req[0]) winner = PORT_I;
      end
      PORT_D: begin
        if (req[2])      winner = PORT_M;
        else if (req[0]) winner = PORT_I;
        else if (req[1]) winner = PORT_D;
      end
      default: begin
        if (req[0])      winner = PORT_I;
        else if (req[1]) winner = PORT_D;
        else if (req[2]) winner = PORT_M;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between
// fetch (i), load/store (d) and monitor (m) ports, with a fixed-latency access FSM.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW  = 10,
  parameter int unsigned DW  = 32,
  parameter int unsigned LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic          d_req,
  input  logic          m_req,
  input  logic [AW-1:0] i_addr,
  input  logic [AW-1:0] d_addr,
  input  logic [AW-1:0] m_addr,
  input  logic          d_we,
  input  logic          m_we,
  input  logic [DW-1:0] d_wdata,
  input  logic [DW-1:0] m_wdata,
  output logic          i_ack,
  output logic          d_ack,
  output logic          m_ack,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner,
  output logic          busy
);

  localparam logic [2:0] LAT_CNT = 3'(LAT);

  state_t        state;
  port_id_t      last_grant;
  port_id_t      winner;
  logic [2:0]    wait_cnt;
  logic          acc_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_we;

  rr_pick3 u_pick (
    .req        ({m_req, d_req, i_req}),
    .last_grant (last_grant),
    .winner     (winner)
  );

  always_comb begin
    sel_addr  = i_addr;
    sel_wdata = '0;
    sel_we    = 1'b0;
    case (winner)
      PORT_D: begin
        sel_addr  = d_addr;
        sel_wdata = d_wdata;
        sel_we    = d_we;
      end
      PORT_M: begin
        sel_addr  = m_addr;
        sel_wdata = m_wdata;
        sel_we    = m_we;
      end
      default: ;
    endcase
  end

  // mem_en/mem_we are loaded on the IDLE->ACCESS edge so they appear in the
  // ACCESS cycle straight from flops; the latched address/data sit in mem_addr/mem_wdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= PORT_M;
      owner      <= PORT_NONE;
      busy       <= 1'b0;
      wait_cnt   <= '0;
      acc_we     <= 1'b0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      m_ack      <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (winner != PORT_NONE) begin
            state      <= ACCESS;
            owner      <= winner;
            last_grant <= winner;
            busy       <= 1'b1;
            acc_we     <= sel_we;
            mem_en     <= 1'b1;
            mem_we     <= sel_we;
            mem_addr   <= sel_addr;
            mem_wdata  <= sel_wdata;
          end
        end
        ACCESS: begin
          mem_en   <= 1'b0;
          mem_we   <= 1'b0;
          wait_cnt <= LAT_CNT;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 3'd1) begin
            if (!acc_we) rdata <= mem_rdata;
            i_ack <= (owner == PORT_I);
            d_ack <= (owner == PORT_D);
            m_ack <= (owner == PORT_M);
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        default: begin
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          m_ack <= 1'b0;
          owner <= PORT_NONE;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: LAT=1 and LAT=3 instances, each with a behavioural memory.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // LAT=1 instance
  logic        i_req1 = 0, d_req1 = 0, m_req1 = 0;
  logic [9:0]  i_addr1 = '0, d_addr1 = '0, m_addr1 = '0;
  logic        d_we1 = 0, m_we1 = 0;
  logic [31:0] d_wdata1 = '0, m_wdata1 = '0;
  logic        i_ack1, d_ack1, m_ack1, mem_en1, mem_we1, busy1;
  logic [31:0] rdata1, mem_wdata1, mem_rdata1;
  logic [9:0]  mem_addr1;
  logic [1:0]  owner1;
  logic [31:0] mem1 [1024];

  // LAT=3 instance
  logic        i_req3 = 0, d_req3 = 0, m_req3 = 0;
  logic [9:0]  i_addr3 = '0, d_addr3 = '0, m_addr3 = '0;
  logic        d_we3 = 0, m_we3 = 0;
  logic [31:0] d_wdata3 = '0, m_wdata3 = '0;
  logic        i_ack3, d_ack3, m_ack3, mem_en3, mem_we3, busy3;
  logic [31:0] rdata3, mem_wdata3, mem_rdata3;
  logic [9:0]  mem_addr3;
  logic [1:0]  owner3;
  logic [31:0] mem3 [1024];

  mem_port_arbiter #(.AW(10), .DW(32), .LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .i_req(i_req1), .d_req(d_req1), .m_req(m_req1),
    .i_addr(i_addr1), .d_addr(d_addr1), .m_addr(m_addr1),
    .d_we(d_we1), .m_we(m_we1), .d_wdata(d_wdata1), .m_wdata(m_wdata1),
    .i_ack(i_ack1), .d_ack(d_ack1), .m_ack(m_ack1), .rdata(rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
    .owner(owner1), .busy(busy1)
  );

  mem_port_arbiter #(.AW(10), .DW(32), .LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .i_req(i_req3), .d_req(d_req3), .m_req(m_req3),
    .i_addr(i_addr3), .d_addr(d_addr3), .m_addr(m_addr3),
    .d_we(d_we3), .m_we(m_we3), .d_wdata(d_wdata3), .m_wdata(m_wdata3),
    .i_ack(i_ack3), .d_ack(d_ack3), .m_ack(m_ack3), .rdata(rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
    .owner(owner3), .busy(busy3)
  );

  // Read data is registered on mem_en and held, so it is stable for any LAT >= 1.
  always @(posedge clk) begin
    if (mem_en1) begin
      if (mem_we1) mem1[mem_addr1] <= mem_wdata1;
      else         mem_rdata1 <= mem1[mem_addr1];
    end
    if (mem_en3) begin
      if (mem_we3) mem3[mem_addr3] <= mem_wdata3;
      else         mem_rdata3 <= mem3[mem_addr3];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] acks1();
    return {29'd0, m_ack1, d_ack1, i_ack1};
  endfunction

  function automatic logic [31:0] acks3();
    return {29'd0, m_ack3, d_ack3, i_ack3};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    mem_rdata1 = '0;
    mem_rdata3 = '0;
    for (int i = 0; i < 1024; i++) begin
      mem1[i] = '0;
      mem3[i] = '0;
    end
    mem1[16] = 32'hDEADBEEF;
    mem1[1]  = 32'h11111111;
    mem1[2]  = 32'h22222222;
    mem3[7]  = 32'hCAFEF00D;

    // reset state
    tick();
    check_eq("rst_owner", {30'd0, owner1}, 32'd0);
    check_eq("rst_busy", {31'd0, busy1}, 32'd0);
    check_eq("rst_mem_en", {31'd0, mem_en1}, 32'd0);
    check_eq("rst_mem_addr", {22'd0, mem_addr1}, 32'd0);
    check_eq("rst_rdata", rdata1, 32'd0);
    check_eq("rst_acks", acks1(), 32'd0);
    rst = 1'b0;

    // single fetch read
    i_addr1 = 10'h010;
    i_req1  = 1'b1;
    tick();
    check_eq("f_mem_en", {31'd0, mem_en1}, 32'd1);
    check_eq("f_mem_addr", {22'd0, mem_addr1}, 32'h010);
    check_eq("f_owner", {30'd0, owner1}, 32'd1);
    check_eq("f_busy", {31'd0, busy1}, 32'd1);
    tick();
    check_eq("f_wait_en", {31'd0, mem_en1}, 32'd0);
    check_eq("f_wait_ack", acks1(), 32'd0);
    tick();
    check_eq("f_ack", acks1(), 32'b001);
    check_eq("f_rdata", rdata1, 32'hDEADBEEF);
    i_req1 = 1'b0;
    tick();
    check_eq("f_idle_busy", {31'd0, busy1}, 32'd0);
    check_eq("f_idle_ack", acks1(), 32'd0);
    check_eq("f_idle_owner", {30'd0, owner1}, 32'd0);

    // simultaneous requests after reset: i, d, m in order
    do_reset();
    d_addr1 = 10'd1;
    m_addr1 = 10'd2;
    i_req1 = 1'b1;
    d_req1 = 1'b1;
    m_req1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] exp_rd;
      exp_rd = (k == 0) ? 32'hDEADBEEF : (k == 1) ? 32'h11111111 : 32'h22222222;
      tick();
      check_eq($sformatf("rr_owner%0d", k), {30'd0, owner1}, k + 1);
      tick();
      tick();
      check_eq($sformatf("rr_ack%0d", k), acks1(), 32'd1 << k);
      check_eq($sformatf("rr_rdata%0d", k), rdata1, exp_rd);
      if (k == 0) i_req1 = 1'b0;
      if (k == 1) d_req1 = 1'b0;
      if (k == 2) m_req1 = 1'b0;
      tick();
      check_eq($sformatf("rr_idle%0d", k), {31'd0, busy1}, 32'd0);
    end

    // data write, then monitor reads it back
    d_addr1  = 10'd5;
    d_we1    = 1'b1;
    d_wdata1 = 32'h12345678;
    d_req1   = 1'b1;
    tick();
    check_eq("w_mem_we", {31'd0, mem_we1}, 32'd1);
    check_eq("w_mem_addr", {22'd0, mem_addr1}, 32'd5);
    check_eq("w_mem_wdata", mem_wdata1, 32'h12345678);
    tick();
    tick();
    check_eq("w_ack", acks1(), 32'b010);
    check_eq("w_rdata_hold", rdata1, 32'h22222222);
    d_req1 = 1'b0;
    d_we1  = 1'b0;
    tick();
    check_eq("w_mem_word", mem1[5], 32'h12345678);
    m_addr1 = 10'd5;
    m_req1  = 1'b1;
    tick();
    tick();
    tick();
    check_eq("mr_ack", acks1(), 32'b100);
    check_eq("mr_rdata", rdata1, 32'h12345678);
    m_req1 = 1'b0;
    tick();

    // reset during WAIT abandons the access
    do_reset();
    i_addr1 = 10'h010;
    i_req1  = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_eq("ra_busy", {31'd0, busy1}, 32'd0);
    check_eq("ra_mem_addr", {22'd0, mem_addr1}, 32'd0);
    check_eq("ra_owner", {30'd0, owner1}, 32'd0);
    check_eq("ra_rdata", rdata1, 32'd0);
    tick();
    check_eq("ra_no_ack", acks1(), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("ra_regrant", {30'd0, owner1}, 32'd1);
    tick();
    check_eq("ra_wait_ack", acks1(), 32'd0);
    tick();
    check_eq("ra_ack", acks1(), 32'b001);
    check_eq("ra_rdata_ok", rdata1, 32'hDEADBEEF);
    i_req1 = 1'b0;
    tick();

    // fairness: m held while i keeps re-requesting
    do_reset();
    i_req1 = 1'b1;
    tick();
    m_addr1 = 10'd2;
    m_req1  = 1'b1;
    tick();
    tick();
    check_eq("fair_i_ack", acks1(), 32'b001);
    tick();
    tick();
    check_eq("fair_m_owner", {30'd0, owner1}, 32'd3);
    tick();
    tick();
    check_eq("fair_m_ack", acks1(), 32'b100);
    check_eq("fair_m_rdata", rdata1, 32'h22222222);
    m_req1 = 1'b0;
    tick();
    tick();
    check_eq("fair_i_again", {30'd0, owner1}, 32'd1);
    i_req1 = 1'b0;
    tick();
    tick();
    check_eq("fair_i_ack2", acks1(), 32'b001);
    tick();

    // LAT=3 instance: d read of addr 7
    d_addr3 = 10'd7;
    d_req3  = 1'b1;
    tick();
    check_eq("l3_mem_en", {31'd0, mem_en3}, 32'd1);
    check_eq("l3_owner", {30'd0, owner3}, 32'd2);
    tick();
    tick();
    tick();
    check_eq("l3_no_early_ack", acks3(), 32'd0);
    tick();
    check_eq("l3_ack", acks3(), 32'b010);
    check_eq("l3_rdata", rdata3, 32'hCAFEF00D);
    tick();
    check_eq("l3_idle_busy", {31'd0, busy3}, 32'd0);
    check_eq("l3_idle_en", {31'd0, mem_en3}, 32'd0);
    tick();
    check_eq("l3_next_grant", {31'd0, mem_en3}, 32'd1);
    d_req3 = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    check_eq("l3_done", {31'd0, busy3}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
